// File: rtl/serial_and_reducer.sv
// ----------------------------------------------------------------------------
// serial_and_reducer
//
// Word-serial AND reduction. Operand words arrive one per cycle on a
// valid/ready stream and are AND-accumulated. After NUM_OPERANDS accepted
// words, one result is offered on a valid/ready output stream.
//
// The result q has the same format as the parallel 8-operand block:
// the upper WIDTH-1 bits are zero, and bit 0 is the AND of every bit of
// every word in the group.
//
// Ports
//   clk        in   1       rising-edge clock
//   rst_n      in   1       asynchronous active-low reset
//   clear      in   1       synchronous abort of partial group and pending result
//   in_valid   in   1       in_data is valid
//   in_ready   out  1       a word can be accepted this cycle (combinational)
//   in_data    in   WIDTH   operand word
//   out_valid  out  1       q holds a completed result
//   out_ready  in   1       consumer takes q this cycle
//   q          out  WIDTH   {WIDTH-1 zeros, AND of the whole group}
//   op_count   out  CNT_W   words accepted so far in the current group
//   acc_zero   out  1       some accumulator bit of the current group is 0
// ----------------------------------------------------------------------------
module serial_and_reducer #(
    parameter  int WIDTH        = 8,
    parameter  int NUM_OPERANDS = 8,
    localparam int CNT_W        = (NUM_OPERANDS > 1) ? $clog2(NUM_OPERANDS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q,
    output logic [CNT_W-1:0] op_count,
    output logic             acc_zero
);

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_e;

    localparam logic [WIDTH-1:0] ACC_ONES  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] RES_ZERO  = {WIDTH{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(NUM_OPERANDS - 1);

    // Final fold of the last word into the accumulator, packed into q's format.
    function automatic logic [WIDTH-1:0] fold_result(
        input logic [WIDTH-1:0] acc,
        input logic [WIDTH-1:0] word
    );
        return {{(WIDTH-1){1'b0}}, &(acc & word)};
    endfunction

    state_e           state_q,     state_d;
    logic [WIDTH-1:0] acc_q,       acc_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [WIDTH-1:0] result_q,    result_d;
    logic             out_valid_q, out_valid_d;
    logic             acc_zero_q,  acc_zero_d;
    logic             in_ready_s;
    logic             accept_s;

    // Input readiness: only while collecting, and never during an abort.
    always_comb begin
        in_ready_s = (state_q == ST_ACCUM) && !clear;
        accept_s   = in_valid && in_ready_s;
    end

    // Next-state computation; clear overrides every handshake.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;
        if (clear) begin
            state_d     = ST_ACCUM;
            acc_d       = ACC_ONES;
            cnt_d       = CNT_ZERO;
            result_d    = RES_ZERO;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_ACCUM: begin
                    // in_data is only looked at on an accept, so an X word
                    // presented without in_valid cannot disturb the state.
                    if (accept_s) begin
                        if (cnt_q == CNT_LAST) begin
                            result_d    = fold_result(acc_q, in_data);
                            out_valid_d = 1'b1;
                            cnt_d       = CNT_ZERO;
                            acc_d       = ACC_ONES;
                            state_d     = ST_HOLD;
                        end else begin
                            acc_d = acc_q & in_data;
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end else begin
                        acc_d = acc_q;
                    end
                end
                ST_HOLD: begin
                    // q stays as-is after the handshake; only reset/clear zero it.
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = ST_ACCUM;
                    end else begin
                        out_valid_d = 1'b1;
                    end
                end
                default: begin
                    state_d     = ST_ACCUM;
                    acc_d       = ACC_ONES;
                    cnt_d       = CNT_ZERO;
                    out_valid_d = 1'b0;
                end
            endcase
        end
        // Tracks the accumulator it is registered alongside, so it falls back
        // to 0 whenever the accumulator is reloaded with all ones.
        acc_zero_d = ~&acc_d;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ACCUM;
            acc_q       <= ACC_ONES;
            cnt_q       <= CNT_ZERO;
            result_q    <= RES_ZERO;
            out_valid_q <= 1'b0;
            acc_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            acc_zero_q  <= acc_zero_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_q;
    assign q         = result_q;
    assign op_count  = cnt_q;
    assign acc_zero  = acc_zero_q;

endmodule

// File: tb/tb_serial_and_reducer.sv
// ----------------------------------------------------------------------------
// Directed bench for serial_and_reducer with WIDTH=7, NUM_OPERANDS=8.
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// ----------------------------------------------------------------------------
module tb_serial_and_reducer;

    localparam int W     = 7;
    localparam int N     = 8;
    localparam int CW    = 3;
    localparam int LIMIT = 50;

    logic          clk;
    logic          rst_n;
    logic          clear;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  q;
    logic [CW-1:0] op_count;
    logic          acc_zero;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    serial_and_reducer #(.WIDTH(W), .NUM_OPERANDS(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .op_count  (op_count),
        .acc_zero  (acc_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Present one word and hold it until it is accepted (bounded wait).
    task automatic send_word(input logic [W-1:0] d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        #0;
        while (!in_ready && n < LIMIT) begin
            tick();
            n++;
        end
        chk("accept_wait", 32'(n < LIMIT), 32'h1);
        tick();
        in_valid = 1'b0;
        in_data  = 'x;
    endtask

    logic [W-1:0] w;
    logic         model;

    initial begin
        rst_n     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;

        // ---------------- reset ----------------
        #12;
        chk("rst_q",         32'(q),         32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_op_count",  32'(op_count),  32'h0);
        chk("rst_acc_zero",  32'(acc_zero),  32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_in_ready", 32'(in_ready), 32'h1);

        // ---------------- 8 x 7F back to back ----------------
        for (int i = 0; i < N - 1; i++) send_word(7'h7F);
        chk("t1_op_count7",  32'(op_count),  32'h7);
        chk("t1_no_valid",   32'(out_valid), 32'h0);
        send_word(7'h7F);
        chk("t1_out_valid",  32'(out_valid), 32'h1);
        chk("t1_q",          32'(q),         32'h01);
        chk("t1_op_count0",  32'(op_count),  32'h0);
        chk("t1_in_ready_hold", 32'(in_ready), 32'h0);
        tick();
        chk("t1_handshake",  32'(out_valid), 32'h0);
        chk("t1_in_ready",   32'(in_ready),  32'h1);

        // ---------------- one 7E at word 4 ----------------
        for (int i = 0; i < 3; i++) send_word(7'h7F);
        chk("t2_acc_zero_pre", 32'(acc_zero), 32'h0);
        send_word(7'h7E);
        chk("t2_acc_zero_w4",  32'(acc_zero), 32'h1);
        for (int i = 0; i < 3; i++) send_word(7'h7F);
        chk("t2_acc_zero_w7",  32'(acc_zero), 32'h1);
        send_word(7'h7F);
        chk("t2_q",            32'(q),         32'h00);
        chk("t2_out_valid",    32'(out_valid), 32'h1);
        chk("t2_acc_zero_done",32'(acc_zero),  32'h0);
        tick();

        // ---------------- backpressure ----------------
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) send_word(7'h7F);
        in_valid = 1'b1;
        in_data  = 7'h00;
        for (int i = 0; i < 5; i++) begin
            chk("t3_bp_in_ready",  32'(in_ready),  32'h0);
            chk("t3_bp_out_valid", 32'(out_valid), 32'h1);
            chk("t3_bp_q",         32'(q),         32'h01);
            chk("t3_bp_op_count",  32'(op_count),  32'h0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("t3_hs_out_valid", 32'(out_valid), 32'h0);
        chk("t3_q_kept",       32'(q),         32'h01);
        chk("t3_op_count",     32'(op_count),  32'h0);
        chk("t3_acc_zero",     32'(acc_zero),  32'h0);

        // ---------------- clear aborts a partial group ----------------
        for (int i = 0; i < 3; i++) send_word(7'h00);
        chk("t4_op_count3",  32'(op_count), 32'h3);
        chk("t4_acc_zero",   32'(acc_zero), 32'h1);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 7'h00;
        #1;
        chk("t4_clear_in_ready", 32'(in_ready), 32'h0);
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        chk("t4_clr_op_count", 32'(op_count), 32'h0);
        chk("t4_clr_acc_zero", 32'(acc_zero), 32'h0);
        chk("t4_clr_q",        32'(q),        32'h0);
        for (int i = 0; i < N; i++) send_word(7'h7F);
        chk("t4_q",          32'(q),         32'h01);
        chk("t4_out_valid",  32'(out_valid), 32'h1);
        tick();

        // ---------------- async reset mid-group ----------------
        for (int i = 0; i < 5; i++) send_word(7'h00);
        chk("t5_op_count5", 32'(op_count), 32'h5);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_q",         32'(q),         32'h0);
        chk("t5_rst_out_valid", 32'(out_valid), 32'h0);
        chk("t5_rst_op_count",  32'(op_count),  32'h0);
        chk("t5_rst_acc_zero",  32'(acc_zero),  32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < N - 1; i++) send_word(7'h7F);
        chk("t5_no_early_valid", 32'(out_valid), 32'h0);
        send_word(7'h7F);
        chk("t5_q",         32'(q),         32'h01);
        chk("t5_out_valid", 32'(out_valid), 32'h1);
        tick();

        // ---------------- random groups with gaps ----------------
        for (int g = 0; g < 10; g++) begin
            model = 1'b1;
            for (int i = 0; i < N; i++) begin
                idle($urandom_range(0, 2));
                if ($urandom_range(0, 5) == 0) w = W'($urandom);
                else w = 7'h7F;
                model = model & (&w);
                send_word(w);
            end
            chk("rnd_out_valid", 32'(out_valid), 32'h1);
            chk("rnd_q",         32'(q),         32'(model));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
